// File: rtl/clk_step_if.sv
// Handshake/status bundle between the front-panel logic and the CPU clock-step controller.
// The master drives the debounced buttons and switches; the controller answers with the enable and its status.
interface clk_step_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       button_pulse;
    logic [7:0]       SW_OK;
    logic             cpu_en;
    logic [1:0]       state;
    logic             running;
    logic [CNT_W-1:0] step_count;
    logic [5:0]       burst_left;

    modport master (
        output button_pulse, SW_OK,
        input  cpu_en, state, running, step_count, burst_left
    );

    modport slave (
        input  button_pulse, SW_OK,
        output cpu_en, state, running, step_count, burst_left
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock-step controller: single step, free run and counted bursts at a
// power-of-two prescaled rate. It emits a one-cycle registered enable per step.
//
// state  | meaning
// HALT   | idle, waiting for a step, run or burst button
// STEP   | one enable is issued on the next edge, then back to HALT
// RUN    | enables every L+1 cycles until the run/halt toggle
// BURST  | like RUN, but stops by itself after burst_left enables
module clk_step_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    clk_step_if.slave  bus
);
    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_STEP  = 2'b01,
        S_RUN   = 2'b10,
        S_BURST = 2'b11
    } state_t;

    state_t           state_q, state_nxt;
    logic [6:0]       presc_q, presc_nxt;
    logic [6:0]       rate_q, rate_nxt;
    logic [5:0]       left_q, left_nxt;
    logic             en_q, en_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       rate_pow;
    logic [6:0]       rate_sel;

    logic btn_step, btn_tog, btn_burst, btn_clr;
    assign btn_step  = bus.button_pulse[0];
    assign btn_tog   = bus.button_pulse[1];
    assign btn_burst = bus.button_pulse[2];
    assign btn_clr   = bus.button_pulse[3];

    // 2^R - 1 computed in 8 bits so R=7 yields 127 rather than wrapping
    assign rate_pow = (8'd1 << bus.SW_OK[2:0]) - 8'd1;
    assign rate_sel = rate_pow[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HALT;
            presc_q <= '0;
            rate_q  <= '0;
            left_q  <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            rate_q  <= rate_nxt;
            left_q  <= left_nxt;
            en_q    <= en_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc_q;
        rate_nxt  = rate_q;
        left_nxt  = left_q;
        en_nxt    = 1'b0;
        cnt_nxt   = cnt_q;

        case (state_q)
            S_HALT: begin
                if (btn_tog) begin
                    state_nxt = S_RUN;
                    rate_nxt  = rate_sel;
                    presc_nxt = '0;
                end else if (btn_burst) begin
                    state_nxt = S_BURST;
                    rate_nxt  = rate_sel;
                    presc_nxt = '0;
                    left_nxt  = {1'b0, bus.SW_OK[7:3]} + 6'd1;
                end else if (btn_step) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                en_nxt    = 1'b1;
                state_nxt = S_HALT;
            end
            S_RUN, S_BURST: begin
                if (btn_tog) begin
                    // the stop request wins over an enable due on the same edge
                    state_nxt = S_HALT;
                    presc_nxt = '0;
                    left_nxt  = '0;
                end else if (presc_q == rate_q) begin
                    en_nxt    = 1'b1;
                    presc_nxt = '0;
                    if (state_q == S_BURST) begin
                        if (left_q <= 6'd1) begin
                            left_nxt  = '0;
                            state_nxt = S_HALT;
                        end else begin
                            left_nxt = left_q - 6'd1;
                        end
                    end
                end else begin
                    presc_nxt = presc_q + 7'd1;
                end
            end
        endcase

        if (en_nxt) cnt_nxt = cnt_q + 1'b1;
        if (btn_clr) cnt_nxt = '0;
    end

    assign bus.cpu_en     = en_q;
    assign bus.state      = state_q;
    assign bus.running    = state_q[1];
    assign bus.step_count = cnt_q;
    assign bus.burst_left = left_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: stimulus pushes the expected enable events,
// a negedge monitor pops one per cpu_en cycle and checks edge index and status.
module tb_clk_step_ctrl;
    localparam int CNT_W = 4;

    typedef struct {
        int         e;
        logic [1:0] st;
        logic [3:0] cnt;
        logic [5:0] left;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   k;
    exp_t q[$];

    clk_step_if #(.CNT_W(CNT_W)) bus ();
    clk_step_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: every enable cycle must match the oldest outstanding expectation
    initial forever begin
        exp_t x;
        @(negedge clk);
        if (bus.cpu_en === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_en: cpu_en high after edge %0d, required no enable", cyc);
            end else begin
                x = q.pop_front();
                if (cyc != x.e || bus.state !== x.st || bus.step_count !== x.cnt ||
                    bus.burst_left !== x.left) begin
                    bad++;
                    $display("FAIL en_event: got edge=%0d st=%0d cnt=%0d left=%0d, required edge=%0d st=%0d cnt=%0d left=%0d",
                             cyc, bus.state, bus.step_count, bus.burst_left, x.e, x.st, x.cnt, x.left);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int e, input logic [1:0] st, input logic [3:0] cnt, input logic [5:0] left);
        exp_t x;
        x.e = e; x.st = st; x.cnt = cnt; x.left = left;
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pulse(input logic [3:0] b);
        bus.button_pulse = b;
        tick();
        bus.button_pulse = 4'b0000;
    endtask

    // wait for all expected enables with a bounded budget, then watch for strays
    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        bus.button_pulse = 4'b1111;
        bus.SW_OK = 8'hFF;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        bus.button_pulse = 4'b0000;
        chk("rst_state", bus.state, 0);
        chk("rst_en", bus.cpu_en, 0);
        chk("rst_cnt", bus.step_count, 0);
        chk("rst_left", bus.burst_left, 0);
        chk("rst_running", bus.running, 0);
        tick();
        chk("idle_state", bus.state, 0);

        // single step: enable two cycles after the pulse edge
        pulse(4'b0001); k = cyc;
        push(k + 1, 2'b00, 4'd1, 6'd0);
        chk("step_state", bus.state, 1);
        drain("step_drain");
        chk("step_cnt", bus.step_count, 1);

        // clear alone, then a 3-enable burst at L=3 with switch changes ignored
        pulse(4'b1000);
        chk("clr_cnt", bus.step_count, 0);
        chk("clr_state", bus.state, 0);
        bus.SW_OK = 8'b00010_010;
        pulse(4'b0100); k = cyc;
        bus.SW_OK = 8'hFF;
        chk("burst_state", bus.state, 3);
        chk("burst_left0", bus.burst_left, 3);
        chk("burst_running", bus.running, 1);
        push(k + 4,  2'b11, 4'd1, 6'd2);
        push(k + 8,  2'b11, 4'd2, 6'd1);
        push(k + 12, 2'b00, 4'd3, 6'd0);
        drain("burst_drain");
        chk("burst_cnt", bus.step_count, 3);
        chk("burst_end_state", bus.state, 0);

        // continuous run at R=0, stopped by a toggle at edge k+11
        pulse(4'b1000);
        bus.SW_OK = 8'h00;
        pulse(4'b0010); k = cyc;
        for (int i = 1; i <= 10; i++) push(k + i, 2'b10, 4'(i), 6'd0);
        repeat (10) tick();
        pulse(4'b0010);
        chk("run_stop_state", bus.state, 0);
        drain("run_drain");
        chk("run_cnt", bus.step_count, 10);

        // clear coinciding with an enable in RUN
        pulse(4'b0010); k = cyc;
        push(k + 1, 2'b10, 4'd11, 6'd0);
        push(k + 2, 2'b10, 4'd12, 6'd0);
        push(k + 3, 2'b10, 4'd0,  6'd0);
        push(k + 4, 2'b10, 4'd1,  6'd0);
        repeat (2) tick();
        pulse(4'b1000);
        tick();
        pulse(4'b0010);
        drain("clr_run_drain");
        chk("clr_run_cnt", bus.step_count, 1);

        // toggle beats burst beats step; step/burst ignored while running
        pulse(4'b0111); k = cyc;
        push(k + 1, 2'b10, 4'd2, 6'd0);
        push(k + 2, 2'b10, 4'd3, 6'd0);
        chk("prio_run", bus.state, 2);
        pulse(4'b0101);
        tick();
        pulse(4'b0010);
        drain("prio_run_drain");
        chk("prio_halt", bus.state, 0);
        pulse(4'b0101); k = cyc;
        push(k + 1, 2'b00, 4'd4, 6'd0);
        chk("prio_burst", bus.state, 3);
        chk("prio_left", bus.burst_left, 1);
        drain("prio_burst_drain");
        chk("prio_end", bus.state, 0);

        // 17 single steps with a 4-bit counter: wraps 15 -> 0, ends at 1
        pulse(4'b1000);
        for (int i = 1; i <= 17; i++) begin
            pulse(4'b0001); k = cyc;
            push(k + 1, 2'b00, 4'(i % 16), 6'd0);
            repeat (2) tick();
        end
        drain("wrap_drain");
        chk("wrap_cnt", bus.step_count, 1);

        // reset mid-burst with burst_left=5, then a normal step
        pulse(4'b1000);
        bus.SW_OK = {5'd7, 3'd0};
        pulse(4'b0100); k = cyc;
        push(k + 1, 2'b11, 4'd1, 6'd7);
        push(k + 2, 2'b11, 4'd2, 6'd6);
        push(k + 3, 2'b11, 4'd3, 6'd5);
        repeat (3) tick();
        chk("pre_rst_left", bus.burst_left, 5);
        rst = 1'b1;
        pulse(4'b0001);
        rst = 1'b0;
        chk("mid_rst_state", bus.state, 0);
        chk("mid_rst_en", bus.cpu_en, 0);
        chk("mid_rst_cnt", bus.step_count, 0);
        chk("mid_rst_left", bus.burst_left, 0);
        chk("mid_rst_running", bus.running, 0);
        drain("rst_drain");
        pulse(4'b0001); k = cyc;
        push(k + 1, 2'b00, 4'd1, 6'd0);
        drain("post_rst_drain");
        chk("post_rst_cnt", bus.step_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the executed-step counter.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 button_pulse  input  4  debounced single-cycle pulses: [0] step, [1] run/halt toggle, [2] burst start, [3] clear step counter.
REQ-005 SW_OK  input  8  debounced switches: [2:0] rate select R, [7:3] burst length minus one.
REQ-006 cpu_en  output  1  registered CPU clock-enable, one cycle per issued step.
REQ-007 state  output  2  HALT=00, STEP=01, RUN=10, BURST=11.
REQ-008 running  output  1  high when state is RUN or BURST.
REQ-009 step_count  output  CNT_W  number of cpu_en cycles issued since reset or clear.
REQ-010 burst_left  output  6  enables remaining in the current burst; 0 outside BURST.

Function
REQ-011 "Edge k" means the rising edge at which a button_pulse bit is sampled high.
REQ-012 HALT + step pulse at edge k: state=STEP after edge k; cpu_en=1 for exactly the cycle after edge k+1; state=HALT after edge k+1.
REQ-013 HALT + toggle at edge k: state=RUN; rate latched as L=2^SW_OK[2:0]-1; prescaler cleared to 0.
REQ-014 HALT + burst at edge k: state=BURST; rate latched as in REQ-013; burst_left=SW_OK[7:3]+1 (range 1..32); prescaler cleared.
REQ-015 RUN/BURST, each edge: if prescaler==L then cpu_en<=1 and prescaler<=0, else cpu_en<=0 and prescaler<=prescaler+1.
REQ-016 The first enable in RUN/BURST occurs after edge k+L+1; enables then repeat every L+1 cycles (R=0: every cycle; R=7: every 128 cycles).
REQ-017 BURST: each issued enable decrements burst_left; the edge issuing the enable that brings burst_left to 0 also sets state=HALT.
REQ-018 RUN/BURST + toggle: state=HALT at that edge; cpu_en=0 from that edge on; prescaler and burst_left cleared.
REQ-019 Step and burst pulses are ignored in RUN, BURST and STEP; toggle is ignored in STEP.
REQ-020 SW_OK changes during RUN/BURST have no effect until the next entry.
REQ-021 cpu_en is low in HALT and in every cycle not selected by REQ-012/REQ-015.
REQ-022 step_count increments by 1 at each edge where cpu_en is being set to 1; it wraps from 2^CNT_W-1 to 0.
REQ-023 A clear pulse sets step_count=0 at edge k, overriding a simultaneous increment; state, cpu_en and prescaler are unaffected.
REQ-024 Simultaneous pulses in HALT: toggle has priority over burst, and burst over step; clear acts independently alongside any of them.
REQ-025 Prescaler width is 7 bits; it never exceeds 127.

Reset
REQ-026 rst high at an edge: state=HALT, cpu_en=0, step_count=0, burst_left=0, prescaler=0, latched rate=0; all pulses in that cycle are ignored.
REQ-027 rst asserted mid-RUN/BURST/STEP aborts immediately; no cpu_en appears after the reset edge.

Verification
REQ-028 HALT, step pulse -> exactly one cpu_en cycle, two cycles after the pulse edge; step_count=1; state returns to 00.
REQ-029 SW_OK=8'b00010_010, burst pulse -> 3 enables spaced 4 cycles apart, first after edge k+4; burst_left 3,2,1,0; state=HALT after the third; step_count=3.
REQ-030 SW_OK[2:0]=0, toggle, 10 cycles, toggle -> cpu_en continuous from edge k+1, with none after the second toggle; step_count=10 (9 enables before the stop edge plus the one set at edge k+1 -- the bench counts edges asserting cpu_en).
REQ-031 CNT_W=4, 17 single steps -> step_count wraps 15 to 0 and ends at 1.
REQ-032 RUN, clear and enable on the same edge -> step_count=0; the next enable gives 1.
REQ-033 rst during BURST with burst_left=5 -> all outputs at reset values on the next cycle; the following step pulse works normally.
